// File: rtl/demux_dispatcher.sv
// Single-entry dispatcher: holds one upstream item and offers it to one of four
// channels, chosen round-robin or directed, counting deliveries per channel.
//
// state | meaning
// EMPTY | no item held, out_valid all-zero, out_data keeps its last value
// FULL  | one item held, offered on its latched target channel only
module demux_dispatcher #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic              flush,
  input  logic              mode,
  input  logic              in_valid,
  input  logic [1:0]        in_sel,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  input  logic [3:0]        out_ready,
  output logic [3:0]        out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        rr_ptr,
  output logic [31:0]       disp_cnt
);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  state_t              state_q, state_d;
  logic [1:0]          tgt_q, tgt_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic [1:0]          rr_q, rr_d;
  logic [31:0]         cnt_q, cnt_d;
  logic                in_fire;
  logic                out_fire;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= EMPTY;
      tgt_q   <= 2'd0;
      data_q  <= '0;
      rr_q    <= 2'd0;
      cnt_q   <= 32'd0;
    end else begin
      state_q <= state_d;
      tgt_q   <= tgt_d;
      data_q  <= data_d;
      rr_q    <= rr_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    out_valid = 4'b0000;
    if (state_q == FULL) begin
      out_valid = 4'b0001 << tgt_q;
    end
    out_fire = |(out_valid & out_ready);
    in_ready = en & ~flush & ((state_q == EMPTY) | out_fire);
    in_fire  = in_valid & in_ready;

    state_d = state_q;
    tgt_d   = tgt_q;
    data_d  = data_q;
    rr_d    = rr_q;
    cnt_d   = cnt_q;

    // A flushed item is dropped uncounted even if its channel was ready.
    if (flush) begin
      state_d = EMPTY;
    end else begin
      if (out_fire) begin
        state_d = EMPTY;
        case (tgt_q)
          2'd0:    cnt_d[7:0]   = cnt_q[7:0]   + 8'd1;
          2'd1:    cnt_d[15:8]  = cnt_q[15:8]  + 8'd1;
          2'd2:    cnt_d[23:16] = cnt_q[23:16] + 8'd1;
          default: cnt_d[31:24] = cnt_q[31:24] + 8'd1;
        endcase
      end
      if (in_fire) begin
        state_d = FULL;
        data_d  = in_data;
        tgt_d   = mode ? in_sel : rr_q;
        if (!mode) begin
          rr_d = rr_q + 2'd1;
        end
      end
    end
  end

  assign out_data = data_q;
  assign rr_ptr   = rr_q;
  assign disp_cnt = cnt_q;

endmodule

// File: tb/tb_demux_dispatcher.sv
// Directed bench for demux_dispatcher: each task drives one scenario and checks
// outputs against hand-computed values; counters carry over between tasks.
module tb_demux_dispatcher;

  logic        clk;
  logic        rst_n;
  logic        en;
  logic        flush;
  logic        mode;
  logic        in_valid;
  logic [1:0]  in_sel;
  logic [7:0]  in_data;
  logic        in_ready;
  logic [3:0]  out_ready;
  logic [3:0]  out_valid;
  logic [7:0]  out_data;
  logic [1:0]  rr_ptr;
  logic [31:0] disp_cnt;

  int checks;
  int errors;

  demux_dispatcher #(.DATA_W(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .flush     (flush),
    .mode      (mode),
    .in_valid  (in_valid),
    .in_sel    (in_sel),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_ready (out_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .rr_ptr    (rr_ptr),
    .disp_cnt  (disp_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; en = 1'b1; flush = 1'b0; mode = 1'b0;
    in_valid = 1'b0; in_sel = 2'd0; in_data = 8'h00; out_ready = 4'h0;
    tick();
    tick();
    rst_n = 1'b1;
    #1;
    checks++;
    if (out_valid !== 4'b0000) begin errors++; $display("FAIL reset_out_valid got %b want 0000", out_valid); end
    checks++;
    if (out_data !== 8'h00) begin errors++; $display("FAIL reset_out_data got %h want 00", out_data); end
    checks++;
    if (rr_ptr !== 2'd0) begin errors++; $display("FAIL reset_rr_ptr got %0d want 0", rr_ptr); end
    checks++;
    if (disp_cnt !== 32'h0) begin errors++; $display("FAIL reset_disp_cnt got %h want 00000000", disp_cnt); end
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
  endtask

  task automatic test_round_robin();
    logic [3:0] exp_v [5];
    logic [1:0] exp_rr [5];
    exp_v  = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    exp_rr = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
    mode = 1'b0; out_ready = 4'hF; in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      in_data = 8'h10 + 8'(i);
      #1;
      checks++;
      if (in_ready !== 1'b1) begin errors++; $display("FAIL rr_in_ready[%0d] got %b want 1", i, in_ready); end
      tick();
      checks++;
      if (out_valid !== exp_v[i]) begin errors++; $display("FAIL rr_out_valid[%0d] got %b want %b", i, out_valid, exp_v[i]); end
      checks++;
      if (out_data !== 8'h10 + 8'(i)) begin errors++; $display("FAIL rr_out_data[%0d] got %h want %h", i, out_data, 8'h10 + 8'(i)); end
      checks++;
      if (rr_ptr !== exp_rr[i]) begin errors++; $display("FAIL rr_ptr[%0d] got %0d want %0d", i, rr_ptr, exp_rr[i]); end
    end
    in_valid = 1'b0;
    tick();
    checks++;
    if (out_valid !== 4'b0000) begin errors++; $display("FAIL rr_drain_valid got %b want 0000", out_valid); end
    checks++;
    if (out_data !== 8'h14) begin errors++; $display("FAIL rr_retain_data got %h want 14", out_data); end
    checks++;
    if (rr_ptr !== 2'd1) begin errors++; $display("FAIL rr_final_ptr got %0d want 1", rr_ptr); end
    checks++;
    if (disp_cnt !== 32'h01010102) begin errors++; $display("FAIL rr_disp_cnt got %h want 01010102", disp_cnt); end
  endtask

  task automatic test_directed_stall();
    mode = 1'b1; in_sel = 2'd2; in_data = 8'hA5; in_valid = 1'b1; out_ready = 4'b1011;
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      // Steering inputs move while the item is held; the target must not.
      mode = i[0]; in_sel = 2'd1;
      #1;
      checks++;
      if (out_valid !== 4'b0100) begin errors++; $display("FAIL stall_out_valid[%0d] got %b want 0100", i, out_valid); end
      checks++;
      if (in_ready !== 1'b0) begin errors++; $display("FAIL stall_in_ready[%0d] got %b want 0", i, in_ready); end
      tick();
    end
    out_ready = 4'b0100; mode = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL stall_drain_in_ready got %b want 1", in_ready); end
    tick();
    checks++;
    if (out_valid !== 4'b0000) begin errors++; $display("FAIL stall_drained got %b want 0000", out_valid); end
    checks++;
    if (disp_cnt !== 32'h01020102) begin errors++; $display("FAIL stall_disp_cnt got %h want 01020102", disp_cnt); end
    checks++;
    if (rr_ptr !== 2'd1) begin errors++; $display("FAIL stall_rr_ptr got %0d want 1", rr_ptr); end
  endtask

  task automatic test_flush_race();
    mode = 1'b1; in_sel = 2'd1; in_data = 8'h3C; in_valid = 1'b1; out_ready = 4'b0000;
    tick();
    checks++;
    if (out_valid !== 4'b0010) begin errors++; $display("FAIL flush_loaded got %b want 0010", out_valid); end
    in_data = 8'hEE; out_ready = 4'b0010; flush = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b0) begin errors++; $display("FAIL flush_in_ready got %b want 0", in_ready); end
    tick();
    flush = 1'b0; in_valid = 1'b0;
    checks++;
    if (out_valid !== 4'b0000) begin errors++; $display("FAIL flush_out_valid got %b want 0000", out_valid); end
    checks++;
    if (disp_cnt !== 32'h01020102) begin errors++; $display("FAIL flush_disp_cnt got %h want 01020102", disp_cnt); end
    checks++;
    if (out_data !== 8'h3C) begin errors++; $display("FAIL flush_out_data got %h want 3C", out_data); end
    checks++;
    if (rr_ptr !== 2'd1) begin errors++; $display("FAIL flush_rr_ptr got %0d want 1", rr_ptr); end
  endtask

  task automatic test_enable_gating();
    en = 1'b0; mode = 1'b0; in_valid = 1'b1; in_data = 8'h66; out_ready = 4'h0;
    #1;
    checks++;
    if (in_ready !== 1'b0) begin errors++; $display("FAIL en_in_ready_empty got %b want 0", in_ready); end
    tick();
    checks++;
    if (out_valid !== 4'b0000 || rr_ptr !== 2'd1) begin
      errors++; $display("FAIL en_no_change got valid %b ptr %0d want 0000 ptr 1", out_valid, rr_ptr);
    end
    en = 1'b1; in_data = 8'h77;
    tick();
    checks++;
    if (out_valid !== 4'b0010 || rr_ptr !== 2'd2) begin
      errors++; $display("FAIL en_accept got valid %b ptr %0d want 0010 ptr 2", out_valid, rr_ptr);
    end
    en = 1'b0; in_data = 8'h88; out_ready = 4'b0010;
    #1;
    checks++;
    if (in_ready !== 1'b0) begin errors++; $display("FAIL en_in_ready_full got %b want 0", in_ready); end
    tick();
    in_valid = 1'b0; en = 1'b1; out_ready = 4'h0;
    checks++;
    if (out_valid !== 4'b0000) begin errors++; $display("FAIL en_drain got %b want 0000", out_valid); end
    checks++;
    if (disp_cnt !== 32'h01020202) begin errors++; $display("FAIL en_disp_cnt got %h want 01020202", disp_cnt); end
    checks++;
    if (out_data !== 8'h77 || rr_ptr !== 2'd2) begin
      errors++; $display("FAIL en_hold got data %h ptr %0d want 77 ptr 2", out_data, rr_ptr);
    end
  endtask

  task automatic test_reset_mid();
    mode = 1'b1; in_sel = 2'd0; in_data = 8'hC3; in_valid = 1'b1; out_ready = 4'h0;
    tick();
    checks++;
    if (out_valid !== 4'b0001 || rr_ptr !== 2'd2) begin
      errors++; $display("FAIL rstmid_loaded got valid %b ptr %0d want 0001 ptr 2", out_valid, rr_ptr);
    end
    rst_n = 1'b0; out_ready = 4'hF; flush = 1'b1; in_valid = 1'b1;
    tick();
    rst_n = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 4'h0;
    checks++;
    if (out_valid !== 4'b0000) begin errors++; $display("FAIL rstmid_out_valid got %b want 0000", out_valid); end
    checks++;
    if (rr_ptr !== 2'd0) begin errors++; $display("FAIL rstmid_rr_ptr got %0d want 0", rr_ptr); end
    checks++;
    if (disp_cnt !== 32'h0) begin errors++; $display("FAIL rstmid_disp_cnt got %h want 00000000", disp_cnt); end
    checks++;
    if (out_data !== 8'h00) begin errors++; $display("FAIL rstmid_out_data got %h want 00", out_data); end
    mode = 1'b0; in_data = 8'h5A; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 4'b0001 || rr_ptr !== 2'd1) begin
      errors++; $display("FAIL rstmid_next got valid %b ptr %0d want 0001 ptr 1", out_valid, rr_ptr);
    end
    out_ready = 4'b0001;
    tick();
    out_ready = 4'h0;
    checks++;
    if (disp_cnt !== 32'h00000001) begin errors++; $display("FAIL rstmid_count got %h want 00000001", disp_cnt); end
  endtask

  task automatic test_counter_wrap();
    mode = 1'b1; in_sel = 2'd3; out_ready = 4'hF; in_valid = 1'b1;
    for (int i = 0; i < 256; i++) begin
      in_data = 8'(i);
      tick();
      if (i == 255) begin
        checks++;
        if (disp_cnt[31:24] !== 8'hFF) begin errors++; $display("FAIL wrap_pre got %h want FF", disp_cnt[31:24]); end
      end
    end
    in_valid = 1'b0;
    tick();
    out_ready = 4'h0;
    checks++;
    if (disp_cnt[31:24] !== 8'h00) begin errors++; $display("FAIL wrap_byte3 got %h want 00", disp_cnt[31:24]); end
    checks++;
    if (disp_cnt[23:0] !== 24'h000001) begin errors++; $display("FAIL wrap_others got %h want 000001", disp_cnt[23:0]); end
    checks++;
    if (out_valid !== 4'b0000 || out_data !== 8'hFF) begin
      errors++; $display("FAIL wrap_final got valid %b data %h want 0000 FF", out_valid, out_data);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_round_robin();
    test_directed_stall();
    test_flush_race();
    test_enable_gating();
    test_reset_mid();
    test_counter_wrap();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/demux_dispatcher.md
DEMUX_DISPATCHER -- requirements
Module: demux_dispatcher

Interface
REQ-001 Parameter: DATA_W, default 8, width of the data word.
REQ-002 clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 rst_n  input  1  reset; synchronous, active-low.
REQ-004 en  input  1  dispatcher enable; low blocks new acceptance.
REQ-005 flush  input  1  discard the held item and clear out_valid.
REQ-006 mode  input  1  0 = round-robin target, 1 = directed target taken from in_sel.
REQ-007 in_valid  input  1  upstream item present.
REQ-008 in_sel  input  2  directed target channel, used when mode=1.
REQ-009 in_data  input  DATA_W  upstream item.
REQ-010 in_ready  output  1  dispatcher accepts an item this cycle.
REQ-011 out_ready  input  4  per-channel readiness, bit k = channel k.
REQ-012 out_valid  output  4  one-hot valid of the held item's target channel; all-zero when empty.
REQ-013 out_data  output  DATA_W  held item, broadcast to all channels; qualified by out_valid.
REQ-014 rr_ptr  output  2  next round-robin target.
REQ-015 disp_cnt  output  32  four 8-bit dispatch counters, channel k in bits [8k+7:8k].

Function
REQ-016 The block SHALL hold one item in a registered holding stage with states EMPTY and FULL.
REQ-017 Accept: in_fire = in_valid & in_ready; out_fire = |(out_valid & out_ready).
REQ-018 in_ready SHALL be en & ~flush & (EMPTY | out_fire), combinationally.
REQ-019 On in_fire the block SHALL latch in_data and the target, and be FULL next cycle; with back-to-back fires, one item per cycle.
REQ-020 Target SHALL be in_sel when mode=1 and rr_ptr when mode=0, sampled at in_fire.
REQ-021 rr_ptr SHALL increment by 1 modulo 4 (3 wraps to 0) only on an in_fire with mode=0; it holds otherwise.
REQ-022 out_valid SHALL be the one-hot of the latched target while FULL; changes to mode or in_sel while FULL SHALL not alter it.
REQ-023 FULL -> EMPTY on out_fire without in_fire; FULL -> FULL with new data/target on simultaneous out_fire and in_fire; EMPTY -> FULL on in_fire.
REQ-024 Readiness on non-target channels SHALL be ignored; the held item waits indefinitely for its target channel.
REQ-025 On out_fire, counter of the target channel SHALL increment by 1, wrapping 255 -> 0.
REQ-026 flush high SHALL force EMPTY next cycle, with no counter increment and no rr_ptr change, even if out_fire occurs in the same cycle.
REQ-027 en low SHALL not stop a held item from draining.
REQ-028 out_data SHALL retain its last value when EMPTY.

Reset
REQ-029 While rst_n is low at a clock edge, next state SHALL be: EMPTY, out_valid=0, out_data=0, rr_ptr=0, disp_cnt=0.
REQ-030 Reset asserted mid-transfer SHALL discard the held item without counting it.
REQ-031 Reset SHALL take precedence over flush, en and all handshakes.

Verification
REQ-032 Round-robin: mode=0, out_ready=4'hF, in_valid held high for 5 cycles with data 0x10..0x14 -> out_valid sequence 0001,0010,0100,1000,0001; rr_ptr returns to 1; disp_cnt=0x01010102.
REQ-033 Directed stall: mode=1, in_sel=2, data 0xA5, out_ready=4'b1011 for 3 cycles, then 4'b0100 -> out_valid=0100 held for 3 cycles with in_ready=0; drains on cycle 4; channel 2 count=1.
REQ-034 Flush race: FULL to channel 1, out_ready[1]=1 and flush=1 in the same cycle -> EMPTY next cycle; channel 1 count unchanged; in_ready=0 during flush.
REQ-035 Counter wrap: 256 dispatches to channel 3 -> disp_cnt[31:24]=0; other bytes unchanged.
REQ-036 Reset mid-operation: FULL to channel 0, rr_ptr=2, rst_n=0 for 1 cycle -> out_valid=0, rr_ptr=0, disp_cnt=0; next accepted item with mode=0 targets channel 0.
REQ-037 Enable gating: en=0 with in_valid=1 -> in_ready=0, no state change; a previously held item still completes on out_ready.
